// File: rtl/lsu_ctrl.sv
// Load/store unit: one access per handshake, aligned word request, extended load result.
// Latency accept->result >= 3 cycles; errors bypass memory; in_ready only in IDLE.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_wen;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_maddr;
  logic [31:0]     r_mwdata;
  logic [3:0]      r_mwmask;
  logic [31:0]     r_rdata;
  logic [1:0]      r_err;

  logic            w_accept;
  logic            w_illegal;
  logic            w_misalign;
  logic [4:0]      w_shift;
  logic [3:0]      w_wmask;
  logic [CW-1:0]   w_cnt_nx;
  logic            w_tmo;
  logic [31:0]     w_t;
  logic [31:0]     w_ld;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_illegal  = in_wen ? (in_funct3[2] || (in_funct3[1:0] == 2'b11))
                             : ((in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11));
  // Illegal encodings are screened first, so funct3[1:0] alone identifies H/W here.
  assign w_misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  assign w_shift    = {in_addr[1:0], 3'b000};
  assign w_cnt_nx   = r_cnt + 1'b1;
  assign w_tmo      = (w_cnt_nx == CW'(TIMEOUT));
  assign w_t        = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_wmask = 4'b0000;
    if (in_wen) begin
      case (in_funct3[1:0])
        2'b00:   w_wmask = 4'b0001 << in_addr[1:0];
        2'b01:   w_wmask = 4'b0011 << in_addr[1:0];
        default: w_wmask = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_ld = {{24{w_t[7]}}, w_t[7:0]};
      3'b100:  w_ld = {24'd0, w_t[7:0]};
      3'b001:  w_ld = {{16{w_t[15]}}, w_t[15:0]};
      3'b101:  w_ld = {16'd0, w_t[15:0]};
      default: w_ld = w_t;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_illegal || w_misalign) ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready) w_next = S_WAIT;
      S_WAIT: if (mem_resp_valid || w_tmo) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE);
    mem_req_valid = (r_state == S_REQ);
    out_valid     = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_cnt    <= '0;
      r_maddr  <= 32'd0;
      r_mwdata <= 32'd0;
      r_mwmask <= 4'd0;
      r_rdata  <= 32'd0;
      r_err    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_wen    <= in_wen;
          r_funct3 <= in_funct3;
          r_off    <= in_addr[1:0];
          r_maddr  <= {in_addr[31:2], 2'b00};
          r_mwdata <= in_wdata << w_shift;
          r_mwmask <= w_wmask;
          r_rdata  <= 32'd0;
          r_err    <= w_illegal ? 2'b11 : (w_misalign ? 2'b01 : 2'b00);
        end
        S_REQ: if (mem_req_ready) r_cnt <= '0;
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_rdata <= r_wen ? 32'd0 : w_ld;
            r_err   <= 2'b00;
          end else begin
            r_cnt <= w_cnt_nx;
            if (w_tmo) begin
              r_rdata <= 32'd0;
              r_err   <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wen   = r_wen;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_mwdata;
  assign mem_wmask = {4'b0000, r_mwmask};
  assign out_rdata = r_rdata;
  assign out_err   = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed vectors, immediate assertions per check.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;

  int n_err = 0;
  int n_chk = 0;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_reqv"},  32'(mem_req_valid), 32'd0);
    chk({tag, "_wen"},   32'(mem_wen), 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, "_outv"},  32'(out_valid), 32'd0);
    chk({tag, "_rdata"}, out_rdata, 32'd0);
    chk({tag, "_err"},   32'(out_err), 32'd0);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  // Present one access and hold it until the accepting edge has passed.
  task automatic accept(input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int n;
    in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_acc_timeout"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Full access at minimum latency; ends in the first DONE cycle.
  task automatic xfer(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic [31:0] e_addr, input logic [31:0] e_wdata,
                      input logic [7:0] e_mask, input string tag);
    accept(wen, f3, addr, wdata, tag);
    chk({tag, "_reqv"},  32'(mem_req_valid), 32'd1);
    chk({tag, "_maddr"}, mem_addr, e_addr);
    chk({tag, "_mwen"},  32'(mem_wen), 32'(wen));
    chk({tag, "_mask"},  32'(mem_wmask), 32'(e_mask));
    if (wen) chk({tag, "_mwdata"}, mem_wdata, e_wdata);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    chk({tag, "_outv"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_inrdy_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    #1;
    chk_cleared("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    xfer(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_1234, 32'h8000_0000, 32'd0, 8'h00, "lb");
    chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
    chk("lb_err", 32'(out_err), 32'd0);
    drain("lb");

    xfer(1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h80FF_1234, 32'h8000_0000, 32'd0, 8'h00, "lbu");
    chk("lbu_rdata", out_rdata, 32'h0000_0080);
    drain("lbu");

    xfer(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555,
         32'h8000_0000, 32'hABCD_0000, 8'h0C, "sh");
    chk("sh_rdata", out_rdata, 32'd0);
    chk("sh_err", 32'(out_err), 32'd0);
    drain("sh");

    xfer(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'd0,
         32'h8000_0008, 32'hCAFE_F00D, 8'h0F, "sw");
    drain("sw");

    xfer(1'b1, 3'b000, 32'h8000_0005, 32'h0000_00A5, 32'd0,
         32'h8000_0004, 32'h0000_A500, 8'h02, "sb");
    drain("sb");

    // Misaligned word load goes straight to DONE without a memory request.
    accept(1'b0, 3'b010, 32'h8000_0002, 32'd0, "lw_mis");
    chk("lw_mis_reqv", 32'(mem_req_valid), 32'd0);
    chk("lw_mis_outv", 32'(out_valid), 32'd1);
    chk("lw_mis_err", 32'(out_err), 32'd1);
    chk("lw_mis_rdata", out_rdata, 32'd0);
    drain("lw_mis");

    accept(1'b0, 3'b011, 32'h8000_0000, 32'd0, "ld_ill");
    chk("ld_ill_reqv", 32'(mem_req_valid), 32'd0);
    chk("ld_ill_err", 32'(out_err), 32'd3);
    drain("ld_ill");

    // funct3 111 at an odd address: illegal wins over misaligned.
    accept(1'b0, 3'b111, 32'h8000_0003, 32'd0, "ld_ill_pri");
    chk("ld_ill_pri_err", 32'(out_err), 32'd3);
    drain("ld_ill_pri");

    accept(1'b1, 3'b101, 32'h8000_0001, 32'hFFFF_FFFF, "st_ill");
    chk("st_ill_reqv", 32'(mem_req_valid), 32'd0);
    chk("st_ill_err", 32'(out_err), 32'd3);
    drain("st_ill");

    accept(1'b1, 3'b001, 32'h8000_0001, 32'h0000_1111, "sh_mis");
    chk("sh_mis_err", 32'(out_err), 32'd1);
    drain("sh_mis");

    // Timeout: 16 WAIT cycles without a response.
    accept(1'b0, 3'b010, 32'h8000_0000, 32'd0, "tmo");
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("tmo_early_outv", 32'(out_valid), 32'd0);
    end
    tick();
    chk("tmo_outv", 32'(out_valid), 32'd1);
    chk("tmo_err", 32'(out_err), 32'd2);
    chk("tmo_rdata", out_rdata, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    chk("tmo_late_err", 32'(out_err), 32'd2);
    chk("tmo_late_rdata", out_rdata, 32'd0);
    drain("tmo");
    xfer(1'b0, 3'b010, 32'h8000_0000, 32'd0, 32'h1357_9BDF, 32'h8000_0000, 32'd0, 8'h00, "lw_after");
    chk("lw_after_rdata", out_rdata, 32'h1357_9BDF);
    chk("lw_after_err", 32'(out_err), 32'd0);
    drain("lw_after");

    // Back-pressure on both memory request and result.
    accept(1'b0, 3'b001, 32'h8000_0006, 32'd0, "stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_reqv", 32'(mem_req_valid), 32'd1);
      chk("stall_maddr", mem_addr, 32'h8000_0004);
      chk("stall_mask", 32'(mem_wmask), 32'd0);
      chk("stall_mwen", 32'(mem_wen), 32'd0);
      chk("stall_inrdy", 32'(in_ready), 32'd0);
      if (i < 4) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h8F00_1234;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_outv", 32'(out_valid), 32'd1);
      chk("stall_rdata", out_rdata, 32'hFFFF_8F00);
      chk("stall_err", 32'(out_err), 32'd0);
      chk("stall_out_inrdy", 32'(in_ready), 32'd0);
      tick();
    end
    drain("stall");

    // Asynchronous reset while waiting for a response.
    accept(1'b0, 3'b010, 32'h8000_0010, 32'd0, "rstw");
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_cleared("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    tick();
    xfer(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h8001_FFFF, 32'h8000_0000, 32'd0, 8'h00, "lhu");
    chk("lhu_rdata", out_rdata, 32'h0000_8001);
    chk("lhu_err", 32'(out_err), 32'd0);
    drain("lhu");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
